irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt request controller that sits directly upstream of `pipeline`. It edge-detects peripheral interrupt lines and gates them by per-source enables and the core's GIE bit. It selects the highest-priority pending source and hands the core a stable vector address through a request/acknowledge handshake. It then tracks the in-service period until the core reports RETI, with no nesting.

## Interface
Parameters:
- `NUM_IRQ`, 14: number of maskable sources; legal range 1–14.
- `VEC_BASE`, 16'hFFE0: vector address of source 0.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `irq_in`  in  NUM_IRQ  raw interrupt lines, rising-edge sensitive.
- `irq_en`  in  NUM_IRQ  per-source enable mask.
- `gie`  in  1  global interrupt enable, taken from `reg_SR_out[3]`.
- `nmi_in`  in  1  non-maskable interrupt line, rising-edge sensitive.
- `irq_ack`  in  1  core has saved PC/SR and fetched the vector.
- `reti`  in  1  core executed RETI; single-cycle pulse.
- `irq_req`  out  1  request to the core's instruction decoder.
- `irq_vec_addr`  out  16  vector table address for the selected source.
- `irq_id`  out  4  selected source; 4'hE denotes NMI.
- `irq_taken`  out  1  one-cycle pulse when a request is accepted.
- `in_service`  out  1  high from acceptance until RETI.

## Operation
- Edge detect:
  - `irq_in_d` and `nmi_d` register the previous samples.
  - rise = in & ~in_d.
  - Each rise sets the matching bit of `pend[NUM_IRQ-1:0]` or `nmi_pend`.
- Eligibility:
  - A source is eligible when `pend[i] & irq_en[i] & gie`.
  - NMI is eligible when `nmi_pend`, regardless of `gie`.
  - Masked pending bits are retained, not cleared.
- Priority:
  - NMI is highest.
  - Among maskable sources, the highest index wins.
- Vector mapping:
  - Source i maps to `VEC_BASE + 2*i` (16-bit add, no wrap for legal `NUM_IRQ`).
  - NMI maps to 16'hFFFC.
  - 16'hFFFE is reserved for `RST_VEC` and is never produced.
- FSM:
  - IDLE: if any source is eligible, latch the winner into `irq_id`/`irq_vec_addr`, assert `irq_req`, and go to REQ.
  - REQ: hold `irq_req`, `irq_id` and `irq_vec_addr` stable; the winner is not re-arbitrated even if a higher source arrives or `gie` falls. On `irq_ack`: clear the winner's pending bit, deassert `irq_req`, pulse `irq_taken`, set `in_service`, and go to SERVICE.
  - SERVICE: no new request is issued. On `reti`: clear `in_service` and go to IDLE.
- Ignored inputs: `irq_ack` outside REQ, and `reti` outside SERVICE.
- Set/clear conflict: if a new rise on the winner coincides with its ack-cycle clear, the set wins and the bit stays pending.
- Reset: every register clears.
  - `irq_req`, `irq_taken` and `in_service` are 0.
  - `irq_id` is 0 and `irq_vec_addr` is 16'h0000.
  - All pending bits and edge history are 0.
  - The FSM returns to IDLE.
  - Reset asserted mid-request or mid-service abandons the transaction.

## Timing
- Line high first sampled at edge k → pending after edge k → `irq_req` after edge k+1 (2-cycle latency from IDLE).
- `irq_ack` sampled at edge m in REQ → after m: `irq_req`=0, `irq_taken`=1 for exactly one cycle, `in_service`=1.
- `reti` sampled at edge r → IDLE after r. The next `irq_req` can appear after edge r+1 if a source is eligible.
- The vector and id registers change only on the IDLE→REQ transition; the core reads them any cycle `irq_req`=1.
- Edges arriving during REQ or SERVICE are captured in pending and serviced after RETI.

## Configuration
- `IRQ_NMI_EN` defined:
  - NMI edge detect, `nmi_pend` and its top priority are compiled in.
  - Id 4'hE maps to 16'hFFFC.
- Undefined:
  - `nmi_in` is ignored and `nmi_pend` is a constant 0.
  - Id 4'hE and 16'hFFFC are never produced.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles with all lines low → all outputs 0; no `irq_req` for 20 cycles.
- Single source: `gie`=1, `irq_en`=14'h0008, rising edge on `irq_in[3]` → `irq_req`=1 two cycles later with `irq_vec_addr`=16'hFFE6 and `irq_id`=3. `irq_ack` → one-cycle `irq_taken`. `reti` → IDLE with `pend[3]`=0.
- Priority and stability:
  - Edges on sources 2 and 9 in the same cycle → `irq_id`=9, vector 16'hFFF2.
  - An edge on 13 during REQ does not change the vector.
  - After RETI, 13 (16'hFFFA) is serviced, then 2.
- Masking: `gie`=0 with an edge on source 5 → no request, `pend[5]` held. Raising `gie` → request with vector 16'hFFEA.
- NMI (`IRQ_NMI_EN` defined): `gie`=0, `nmi_in` edge plus pending source 12 → `irq_id`=4'hE, vector 16'hFFFC. Without the macro, the same stimulus produces no request.
- Reset mid-service: assert `rst` in SERVICE with source 1 pending → all outputs 0, pending cleared, FSM in IDLE.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detected, maskable sources with fixed priority and a
// req/ack/reti handshake to the core. Define IRQ_NMI_EN to compile in the NMI source.
module irq_ctrl #(
    parameter int unsigned NUM_IRQ  = 14,
    parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               gie,
    input  logic               nmi_in,
    input  logic               irq_ack,
    input  logic               reti,
    output logic               irq_req,
    output logic [15:0]        irq_vec_addr,
    output logic [3:0]         irq_id,
    output logic               irq_taken,
    output logic               in_service
);

    localparam logic [3:0]  NMI_ID  = 4'hE;
    localparam logic [15:0] NMI_VEC = 16'hFFFC;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t              state, state_nxt;
    logic [NUM_IRQ-1:0]  irq_in_d;
    logic [NUM_IRQ-1:0]  pend;
    logic [NUM_IRQ-1:0]  pend_set_c, pend_clr_c, elig_c;
    logic                nmi_pend, nmi_set_c, nmi_clr_c;
    logic                any_elig_c;
    logic [3:0]          win_id_c;
    logic [15:0]         win_vec_c;
    logic                req_nxt, taken_nxt, svc_nxt;
    logic [3:0]          id_nxt;
    logic [15:0]         vec_nxt;

    always_comb begin
        pend_set_c = irq_in & ~irq_in_d;
        elig_c     = pend & irq_en & {NUM_IRQ{gie}};
    end

`ifdef IRQ_NMI_EN
    logic nmi_d;

    assign nmi_set_c = nmi_in & ~nmi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_d    <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            nmi_d    <= nmi_in;
            nmi_pend <= (nmi_pend & ~nmi_clr_c) | nmi_set_c;
        end
    end
`else
    logic [1:0] unused_nmi;

    assign nmi_set_c  = 1'b0;
    assign nmi_pend   = 1'b0;
    assign unused_nmi = {nmi_in, nmi_clr_c | nmi_set_c};
`endif

    // Fixed-priority arbiter: NMI first, then the highest eligible index.
    always_comb begin
        any_elig_c = |elig_c;
        win_id_c   = 4'd0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (elig_c[i]) win_id_c = 4'(i);
        end
        win_vec_c = VEC_BASE + {11'd0, win_id_c, 1'b0};
        if (nmi_pend) begin
            any_elig_c = 1'b1;
            win_id_c   = NMI_ID;
            win_vec_c  = NMI_VEC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_nxt    = irq_req;
        taken_nxt  = 1'b0;
        svc_nxt    = in_service;
        id_nxt     = irq_id;
        vec_nxt    = irq_vec_addr;
        pend_clr_c = '0;
        nmi_clr_c  = 1'b0;
        case (state)
            IDLE: begin
                if (any_elig_c) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    id_nxt    = win_id_c;
                    vec_nxt   = win_vec_c;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_nxt = SERVICE;
                    req_nxt   = 1'b0;
                    taken_nxt = 1'b1;
                    svc_nxt   = 1'b1;
                    if (irq_id == NMI_ID) begin
                        nmi_clr_c = 1'b1;
                    end else begin
                        for (int i = 0; i < int'(NUM_IRQ); i++) begin
                            if (4'(i) == irq_id) pend_clr_c[i] = 1'b1;
                        end
                    end
                end
            end
            SERVICE: begin
                if (reti) begin
                    state_nxt = IDLE;
                    svc_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new edge on the winner in its ack cycle keeps the bit pending (set wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_in_d     <= '0;
            pend         <= '0;
            irq_req      <= 1'b0;
            irq_taken    <= 1'b0;
            in_service   <= 1'b0;
            irq_id       <= 4'd0;
            irq_vec_addr <= 16'h0000;
        end else begin
            irq_in_d     <= irq_in;
            pend         <= (pend & ~pend_clr_c) | pend_set_c;
            irq_req      <= req_nxt;
            irq_taken    <= taken_nxt;
            in_service   <= svc_nxt;
            irq_id       <= id_nxt;
            irq_vec_addr <= vec_nxt;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized and directed bench for irq_ctrl against a behavioural reference model.
module tb_irq_ctrl;

    localparam int unsigned N = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  irq_in = '0;
    logic [N-1:0]  irq_en = '0;
    logic          gie = 1'b0;
    logic          nmi_in = 1'b0;
    logic          irq_ack = 1'b0;
    logic          reti = 1'b0;
    logic          irq_req;
    logic [15:0]   irq_vec_addr;
    logic [3:0]    irq_id;
    logic          irq_taken;
    logic          in_service;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int            m_phase;          // 0 waiting, 1 requesting, 2 in service
    logic [N-1:0]  m_pend, m_prev;
    logic          m_npend, m_nprev;
    logic          m_req, m_taken, m_svc;
    logic [3:0]    m_id;
    logic [15:0]   m_vec;

    irq_ctrl #(.NUM_IRQ(N), .VEC_BASE(16'hFFE0)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_en(irq_en), .gie(gie),
        .nmi_in(nmi_in), .irq_ack(irq_ack), .reti(reti), .irq_req(irq_req),
        .irq_vec_addr(irq_vec_addr), .irq_id(irq_id), .irq_taken(irq_taken),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [N-1:0] rise, clr;
        logic         nrise, nclr;
        int           w;
        if (rst) begin
            m_phase = 0; m_pend = '0; m_prev = '0; m_npend = 1'b0; m_nprev = 1'b0;
            m_req = 1'b0; m_taken = 1'b0; m_svc = 1'b0; m_id = 4'd0; m_vec = 16'h0000;
            return;
        end
        rise = irq_in & ~m_prev;
`ifdef IRQ_NMI_EN
        nrise = nmi_in & ~m_nprev;
`else
        nrise = 1'b0;
`endif
        clr = '0; nclr = 1'b0; m_taken = 1'b0;
        if (m_phase == 0) begin
            w = -1;
            if (m_npend) w = 14;
            else begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (w < 0 && m_pend[i] && irq_en[i] && gie) w = i;
                end
            end
            if (w >= 0) begin
                m_id    = 4'(w);
                m_vec   = (w == 14) ? 16'hFFFC : 16'(32'hFFE0 + 2 * w);
                m_req   = 1'b1;
                m_phase = 1;
            end
        end else if (m_phase == 1 && irq_ack) begin
            if (m_id == 4'hE) nclr = 1'b1;
            else clr[m_id] = 1'b1;
            m_req = 1'b0; m_taken = 1'b1; m_svc = 1'b1; m_phase = 2;
        end else if (m_phase == 2 && reti) begin
            m_svc = 1'b0; m_phase = 0;
        end
        m_pend  = (m_pend & ~clr) | rise;
        m_npend = (m_npend & ~nclr) | nrise;
        m_prev  = irq_in;
        m_nprev = nmi_in;
    endtask

    // One clock: update model at the edge, compare all outputs just after it.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("irq_req",      {15'd0, irq_req},    {15'd0, m_req});
        check("irq_taken",    {15'd0, irq_taken},  {15'd0, m_taken});
        check("in_service",   {15'd0, in_service}, {15'd0, m_svc});
        check("irq_id",       {12'd0, irq_id},     {12'd0, m_id});
        check("irq_vec_addr", irq_vec_addr,        m_vec);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
    endtask

    task automatic pulse_reti();
        reti = 1'b1; step(); reti = 1'b0;
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1; step(); step();
        check("reset_req", {15'd0, irq_req}, 16'd0);
        check("reset_vec", irq_vec_addr, 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("idle_req", {15'd0, irq_req}, 16'd0);

        // Single source 3
        gie = 1'b1; irq_en = 14'h0008;
        irq_in[3] = 1'b1; step();
        check("single_early", {15'd0, irq_req}, 16'd0);
        step();
        check("single_req", {15'd0, irq_req}, 16'd1);
        check("single_vec", irq_vec_addr, 16'hFFE6);
        check("single_id", {12'd0, irq_id}, 16'd3);
        pulse_ack();
        check("single_taken", {15'd0, irq_taken}, 16'd1);
        step();
        check("single_taken_off", {15'd0, irq_taken}, 16'd0);
        irq_in[3] = 1'b0;
        pulse_reti();
        for (int i = 0; i < 3; i++) step();
        check("single_cleared", {15'd0, irq_req}, 16'd0);

        // Priority and stability
        irq_en = 14'h3FFF;
        irq_in[2] = 1'b1; irq_in[9] = 1'b1; step(); step();
        check("prio_id", {12'd0, irq_id}, 16'd9);
        check("prio_vec", irq_vec_addr, 16'hFFF2);
        irq_in[13] = 1'b1; step(); step();
        check("stable_vec", irq_vec_addr, 16'hFFF2);
        irq_in = '0;
        pulse_ack(); step(); pulse_reti(); step();
        check("next_vec13", irq_vec_addr, 16'hFFFA);
        pulse_ack(); pulse_reti(); step();
        check("next_id2", {12'd0, irq_id}, 16'd2);
        pulse_ack(); pulse_reti(); step();

        // Masking by gie
        irq_en = 14'h0020; gie = 1'b0;
        irq_in[5] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("masked_req", {15'd0, irq_req}, 16'd0);
        gie = 1'b1; step();
        check("unmask_vec", irq_vec_addr, 16'hFFEA);
        irq_in[5] = 1'b0;
        pulse_ack(); pulse_reti(); step();

        // NMI with gie low and source 12 pending
        gie = 1'b0; irq_en = 14'h1000;
        irq_in[12] = 1'b1; nmi_in = 1'b1; step(); step();
`ifdef IRQ_NMI_EN
        check("nmi_id", {12'd0, irq_id}, 16'h000E);
        check("nmi_vec", irq_vec_addr, 16'hFFFC);
        pulse_ack(); pulse_reti();
`else
        check("nmi_absent", {15'd0, irq_req}, 16'd0);
`endif
        irq_in = '0; nmi_in = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;

        // Reset mid-service with source 1 pending
        gie = 1'b1; irq_en = 14'h3FFF;
        irq_in[1] = 1'b1; irq_in[4] = 1'b1; step(); step();
        pulse_ack(); step();
        check("svc_before_rst", {15'd0, in_service}, 16'd1);
        rst = 1'b1; irq_in = '0; step();
        check("rst_svc", {15'd0, in_service}, 16'd0);
        check("rst_id", {12'd0, irq_id}, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("rst_pend_cleared", {15'd0, irq_req}, 16'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
            end
            if ($urandom_range(0, 49) == 0) irq_en = 14'($urandom);
            gie     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) nmi_in = ~nmi_in;
            irq_ack = ($urandom_range(0, 2) == 0);
            reti    = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
